// File: rtl/sprite_animator.sv
// Animated sprite renderer for the VGA path. Position and flip are latched once per video
// frame, and the pixel pipeline has three cycles of latency.
module sprite_animator #(
  parameter int          SPR_W      = 60,
  parameter int          SPR_H      = 90,
  parameter int          SCALE_LOG2 = 1,
  parameter int          NUM_FRAMES = 4,
  parameter int          FRAME_HOLD = 6,
  parameter bit          LOOP       = 1'b1,
  parameter int          ADDR_W     = 15,
  parameter logic [11:0] KEY_RGB    = 12'hF0F,
  localparam int         FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               vga_clk,
  input  logic               Reset,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  input  logic               frame_start,
  input  logic [9:0]         PosX,
  input  logic [9:0]         PosY,
  input  logic               flip,
  input  logic               anim_en,
  input  logic               anim_restart,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [3:0]         rom_q,
  input  logic [3:0]         pal_r,
  input  logic [3:0]         pal_g,
  input  logic [3:0]         pal_b,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               sprite_on,
  output logic [FRAME_W-1:0] anim_frame,
  output logic               anim_done
);

  localparam int                HOLD_W   = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [10:0]       BOX_W    = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0]       BOX_H    = 11'(SPR_H << SCALE_LOG2);
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPR_W * SPR_H);

  typedef enum logic {PLAY = 1'b0, HOLD_LAST = 1'b1} state_t;

  state_t              state_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [FRAME_W-1:0]  frame_q;
  logic                done_q;
  logic [9:0]          px_q, py_q;
  logic                flip_q;
  logic [ADDR_W-1:0]   rom_addr_q, addr_d;
  logic                hit_d1_q, blank_d1_q, hit_d2_q, blank_d2_q;
  logic                sprite_on_q, on_d;
  logic [11:0]         rgb_q, rgb_d, pal_rgb_s;
  logic [10:0]         lx_s, ly_s, col_raw_s, col_s, row_s;
  logic                hit_s;

  // Shadow position/flip, only updated at a frame boundary to avoid tearing.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      px_q   <= 10'd0;
      py_q   <= 10'd0;
      flip_q <= 1'b0;
    end else if (frame_start) begin
      px_q   <= PosX;
      py_q   <= PosY;
      flip_q <= flip;
    end
  end

  // Hit test and texel address; 11-bit offsets make off-screen parts clip rather than wrap.
  always_comb begin
    lx_s      = {1'b0, DrawX} - {1'b0, px_q};
    ly_s      = {1'b0, DrawY} - {1'b0, py_q};
    hit_s     = (DrawX >= px_q) && (DrawY >= py_q) && (lx_s < BOX_W) && (ly_s < BOX_H);
    col_raw_s = lx_s >> SCALE_LOG2;
    row_s     = ly_s >> SCALE_LOG2;
    if (flip_q) begin
      col_s = 11'(SPR_W - 1) - col_raw_s;
    end else begin
      col_s = col_raw_s;
    end
    if (hit_s) begin
      addr_d = ADDR_W'(frame_q) * FRAME_SZ + ADDR_W'(row_s) * ADDR_W'(SPR_W) + ADDR_W'(col_s);
    end else begin
      addr_d = {ADDR_W{1'b0}};
    end
  end

  // Colour-key transparency on the palette colour returned for the ROM texel.
  always_comb begin
    pal_rgb_s = {pal_r, pal_g, pal_b};
    on_d      = hit_d2_q & blank_d2_q & (pal_rgb_s != KEY_RGB);
    if (on_d) begin
      rgb_d = pal_rgb_s;
    end else begin
      rgb_d = 12'h000;
    end
  end

  // Three-stage pixel pipeline: address, ROM read, colour.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      rom_addr_q  <= {ADDR_W{1'b0}};
      hit_d1_q    <= 1'b0;
      blank_d1_q  <= 1'b0;
      hit_d2_q    <= 1'b0;
      blank_d2_q  <= 1'b0;
      sprite_on_q <= 1'b0;
      rgb_q       <= 12'h000;
    end else begin
      rom_addr_q  <= addr_d;
      hit_d1_q    <= hit_s;
      blank_d1_q  <= blank;
      hit_d2_q    <= hit_d1_q;
      blank_d2_q  <= blank_d1_q;
      sprite_on_q <= on_d;
      rgb_q       <= rgb_d;
    end
  end

  // Animation sequencer; restart overrides any advance on the same cycle.
  always_ff @(posedge vga_clk) begin
    if (Reset || anim_restart) begin
      state_q <= PLAY;
      hold_q  <= {HOLD_W{1'b0}};
      frame_q <= {FRAME_W{1'b0}};
      done_q  <= 1'b0;
    end else if (frame_start && anim_en) begin
      case (state_q)
        PLAY: begin
          if (hold_q == HOLD_W'(FRAME_HOLD - 1)) begin
            hold_q <= {HOLD_W{1'b0}};
            if (frame_q < FRAME_W'(NUM_FRAMES - 1)) begin
              frame_q <= frame_q + FRAME_W'(1);
            end else if (LOOP) begin
              frame_q <= {FRAME_W{1'b0}};
            end else begin
              state_q <= HOLD_LAST;
              done_q  <= 1'b1;
            end
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        HOLD_LAST: begin
          frame_q <= FRAME_W'(NUM_FRAMES - 1);
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= PLAY;
        end
      endcase
    end
  end

  assign rom_addr   = rom_addr_q;
  assign sprite_on  = sprite_on_q;
  assign {red, green, blue} = rgb_q;
  assign anim_frame = frame_q;
  assign anim_done  = done_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Self-checking bench for sprite_animator: directed scenarios plus a randomized stream
// compared against a pixel/animation model kept in the bench.
module tb_sprite_animator;
  localparam int SPR_W = 60, SPR_H = 90, SC = 2, NF = 4, FH = 6, FSZ = SPR_W * SPR_H;

  logic       vga_clk = 1'b0;
  logic       Reset, blank, frame_start, flip, anim_en, anim_restart;
  logic [9:0] DrawX, DrawY, PosX, PosY;
  logic [14:0] rom_addr, rom_addr1;
  logic [3:0] rom_q, rom_q1, pal_r, pal_g, pal_b, pal_r1, pal_g1, pal_b1;
  logic [3:0] red, green, blue, red1, green1, blue1;
  logic       sprite_on, sprite_on1, anim_done, anim_done1;
  logic [1:0] anim_frame, anim_frame1;

  logic [3:0]  mem [0:NF*FSZ-1];
  logic [11:0] pal_tab [0:15];
  int n_vec = 0, n_err = 0;

  typedef struct packed { logic hit; logic blk; logic [15:0] addr; } pix_t;
  pix_t h1, h2, h3;
  int m_px, m_py, m_n;
  bit m_flip;

  always #5 vga_clk = ~vga_clk;

  always_ff @(posedge vga_clk) rom_q  <= mem[rom_addr];
  always_ff @(posedge vga_clk) rom_q1 <= mem[rom_addr1];
  assign {pal_r, pal_g, pal_b}    = pal_tab[rom_q];
  assign {pal_r1, pal_g1, pal_b1} = pal_tab[rom_q1];

  sprite_animator u_loop (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .PosX(PosX), .PosY(PosY), .flip(flip), .anim_en(anim_en),
    .anim_restart(anim_restart), .rom_addr(rom_addr), .rom_q(rom_q), .pal_r(pal_r),
    .pal_g(pal_g), .pal_b(pal_b), .red(red), .green(green), .blue(blue),
    .sprite_on(sprite_on), .anim_frame(anim_frame), .anim_done(anim_done));

  sprite_animator #(.LOOP(1'b0)) u_once (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .PosX(PosX), .PosY(PosY), .flip(flip), .anim_en(anim_en),
    .anim_restart(anim_restart), .rom_addr(rom_addr1), .rom_q(rom_q1), .pal_r(pal_r1),
    .pal_g(pal_g1), .pal_b(pal_b1), .red(red1), .green(green1), .blue(blue1),
    .sprite_on(sprite_on1), .anim_frame(anim_frame1), .anim_done(anim_done1));

  // Animation is a pure function of the number of enabled frame_start pulses since restart.
  function automatic int m_frame();
    return (m_n / FH) % NF;
  endfunction
  function automatic int m_frame_once();
    return (m_n / FH >= NF) ? NF - 1 : m_n / FH;
  endfunction

  function automatic pix_t model_pix(int x, int y, logic b);
    pix_t p;
    int col, row;
    p.blk  = b;
    p.hit  = (x >= m_px) && (y >= m_py) && (x - m_px < SPR_W * SC) && (y - m_py < SPR_H * SC);
    p.addr = 16'd0;
    if (p.hit) begin
      col = (x - m_px) / SC;
      row = (y - m_py) / SC;
      if (m_flip) col = SPR_W - 1 - col;
      p.addr = 16'(m_frame() * FSZ + row * SPR_W + col);
    end
    return p;
  endfunction

  // One clock: record the expectation for the current inputs, then update model state.
  task automatic tick();
    pix_t e;
    e = model_pix(int'(DrawX), int'(DrawY), blank);
    @(posedge vga_clk);
    if (Reset) begin
      h1 = '0; h2 = '0; h3 = '0;
      m_px = 0; m_py = 0; m_flip = 1'b0; m_n = 0;
    end else begin
      h3 = h2; h2 = h1; h1 = e;
      if (anim_restart) m_n = 0;
      else if (frame_start && anim_en) m_n++;
      if (frame_start) begin
        m_px = int'(PosX); m_py = int'(PosY); m_flip = flip;
      end
    end
    #1;
  endtask

  task automatic pulse(input logic restart);
    frame_start = 1'b1; anim_restart = restart; tick();
    frame_start = 1'b0; anim_restart = 1'b0; tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1; tick(); tick(); tick();
    n_vec++; if (rom_addr !== 15'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", rom_addr); end
    n_vec++; if (sprite_on !== 1'b0) begin n_err++; $display("FAIL reset_on got %b want 0", sprite_on); end
    n_vec++; if ({red, green, blue} !== 12'h000) begin n_err++; $display("FAIL reset_rgb got %h want 000", {red, green, blue}); end
    n_vec++; if (anim_frame !== 2'd0 || anim_done !== 1'b0 || anim_done1 !== 1'b0) begin
      n_err++; $display("FAIL reset_anim got frame %0d done %b/%b want 0 0/0", anim_frame, anim_done, anim_done1); end
    Reset = 1'b0;
  endtask

  task automatic test_static();
    PosX = 10'd100; PosY = 10'd50; flip = 1'b0; blank = 1'b1; DrawX = 10'd0; DrawY = 10'd0;
    pulse(1'b0);
    DrawX = 10'd100; DrawY = 10'd50; tick();
    n_vec++; if (rom_addr !== 15'd0) begin n_err++; $display("FAIL static_origin got %0d want 0", rom_addr); end
    DrawX = 10'd219; tick();
    n_vec++; if (rom_addr !== 15'd59) begin n_err++; $display("FAIL static_right got %0d want 59", rom_addr); end
    DrawX = 10'd220; tick();
    n_vec++; if (rom_addr !== 15'd0) begin n_err++; $display("FAIL static_past got %0d want 0", rom_addr); end
    DrawX = 10'd101; DrawY = 10'd53; tick();
    n_vec++; if (rom_addr !== 15'd60) begin n_err++; $display("FAIL static_row1 got %0d want 60", rom_addr); end
    DrawX = 10'd0; DrawY = 10'd0; tick();
    n_vec++; if (sprite_on !== 1'b0) begin n_err++; $display("FAIL static_past_on got %b want 0", sprite_on); end
  endtask

  task automatic test_flip();
    flip = 1'b1; pulse(1'b0); flip = 1'b0;
    DrawX = 10'd100; DrawY = 10'd52; tick();
    n_vec++; if (rom_addr !== 15'd119) begin n_err++; $display("FAIL flip_addr got %0d want 119", rom_addr); end
    tick();
    n_vec++; if (rom_addr !== 15'd119) begin n_err++; $display("FAIL flip_latched got %0d want 119", rom_addr); end
  endtask

  task automatic test_colour();
    mem[0] = 4'd9; mem[1] = 4'd5;
    DrawX = 10'd0; DrawY = 10'd0; flip = 1'b0; pulse(1'b0); tick();
    DrawX = 10'd100; DrawY = 10'd50; tick();
    DrawX = 10'd102; tick();
    n_vec++; if (sprite_on !== 1'b0) begin n_err++; $display("FAIL colour_early got %b want 0", sprite_on); end
    DrawX = 10'd0; DrawY = 10'd0; tick();
    n_vec++; if (sprite_on !== 1'b1 || {red, green, blue} !== 12'h3A7) begin
      n_err++; $display("FAIL colour_opaque got %b %h want 1 3a7", sprite_on, {red, green, blue}); end
    tick();
    n_vec++; if (sprite_on !== 1'b0 || {red, green, blue} !== 12'h000) begin
      n_err++; $display("FAIL colour_key got %b %h want 0 000", sprite_on, {red, green, blue}); end
  endtask

  task automatic test_animation();
    int ef, eo;
    anim_en = 1'b1; PosX = 10'd100; PosY = 10'd50; DrawX = 10'd100; DrawY = 10'd50;
    anim_restart = 1'b1; tick(); anim_restart = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      pulse(1'b0);
      ef = (k / FH) % NF;
      eo = (k / FH >= NF) ? NF - 1 : k / FH;
      n_vec++; if (anim_frame !== 2'(ef)) begin n_err++; $display("FAIL anim_loop k=%0d got %0d want %0d", k, anim_frame, ef); end
      n_vec++; if (anim_frame1 !== 2'(eo) || anim_done1 !== (k >= 24)) begin
        n_err++; $display("FAIL anim_once k=%0d got %0d/%b want %0d/%b", k, anim_frame1, anim_done1, eo, k >= 24); end
      n_vec++; if (rom_addr !== 15'(ef * FSZ)) begin n_err++; $display("FAIL anim_base k=%0d got %0d want %0d", k, rom_addr, ef * FSZ); end
    end
  endtask

  task automatic test_edges();
    anim_restart = 1'b1; tick(); anim_restart = 1'b0;
    PosX = 10'd600; PosY = 10'd50; pulse(1'b0);
    DrawX = 10'd639; DrawY = 10'd52; tick();
    n_vec++; if (rom_addr !== 15'd79) begin n_err++; $display("FAIL edge_639 got %0d want 79", rom_addr); end
    DrawX = 10'd0; tick();
    n_vec++; if (rom_addr !== 15'd0) begin n_err++; $display("FAIL edge_nowrap got %0d want 0", rom_addr); end
    tick(); tick();
    n_vec++; if (sprite_on !== 1'b0) begin n_err++; $display("FAIL edge_nowrap_on got %b want 0", sprite_on); end
    for (int k = 0; k < 4; k++) pulse(1'b0);
    PosX = 10'd200; PosY = 10'd50; pulse(1'b1);
    n_vec++; if (anim_frame !== 2'd0) begin n_err++; $display("FAIL edge_restart got %0d want 0", anim_frame); end
    PosX = 10'd300; DrawX = 10'd202; DrawY = 10'd50; tick();
    n_vec++; if (rom_addr !== 15'd1) begin n_err++; $display("FAIL edge_relatch got %0d want 1", rom_addr); end
    DrawX = 10'd300; tick();
    n_vec++; if (rom_addr !== 15'd50) begin n_err++; $display("FAIL edge_midframe got %0d want 50", rom_addr); end
    PosX = 10'd200;
    for (int k = 0; k < 5; k++) pulse(1'b0);
    n_vec++; if (anim_frame !== 2'd0) begin n_err++; $display("FAIL edge_hold_reset got %0d want 0", anim_frame); end
    pulse(1'b0);
    n_vec++; if (anim_frame !== 2'd1) begin n_err++; $display("FAIL edge_advance got %0d want 1", anim_frame); end
    anim_en = 1'b0;
    for (int k = 0; k < 7; k++) pulse(1'b0);
    n_vec++; if (anim_frame !== 2'd1) begin n_err++; $display("FAIL edge_freeze got %0d want 1", anim_frame); end
  endtask

  task automatic test_reset_midline();
    mem[FSZ] = 4'd9;
    PosX = 10'd100; PosY = 10'd50; blank = 1'b1; DrawX = 10'd100; DrawY = 10'd50;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (sprite_on !== 1'b1 || anim_frame !== 2'd1) begin
      n_err++; $display("FAIL midline_pre got %b/%0d want 1/1", sprite_on, anim_frame); end
    Reset = 1'b1; tick();
    n_vec++; if (sprite_on !== 1'b0 || {red, green, blue} !== 12'h000 || rom_addr !== 15'd0 || anim_frame !== 2'd0) begin
      n_err++; $display("FAIL midline_reset got %b %h %0d %0d want 0 000 0 0", sprite_on, {red, green, blue}, rom_addr, anim_frame); end
    Reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++; if (sprite_on !== 1'b0) begin n_err++; $display("FAIL midline_after%0d got %b want 0", k, sprite_on); end
    end
  endtask

  task automatic test_random_stream();
    logic [11:0] ec;
    logic        eon;
    for (int i = 0; i < 800; i++) begin
      frame_start = ($urandom_range(0, 3) == 0);
      if (frame_start) begin
        PosX = 10'($urandom_range(0, 639)); PosY = 10'($urandom_range(0, 479)); flip = 1'($urandom_range(0, 1));
      end
      anim_en      = ($urandom_range(0, 3) != 0);
      anim_restart = ($urandom_range(0, 63) == 0);
      blank        = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        DrawX = 10'($urandom); DrawY = 10'($urandom);
      end else begin
        DrawX = 10'(m_px + int'($urandom_range(0, 130)) - 5);
        DrawY = 10'(m_py + int'($urandom_range(0, 190)) - 5);
      end
      tick();
      ec  = pal_tab[mem[h3.addr]];
      eon = h3.hit && h3.blk && (ec != 12'hF0F);
      if (!eon) ec = 12'h000;
      n_vec++; if (rom_addr !== h1.addr[14:0]) begin n_err++; $display("FAIL rand_addr i=%0d got %0d want %0d", i, rom_addr, h1.addr); end
      n_vec++; if (sprite_on !== eon || {red, green, blue} !== ec) begin
        n_err++; $display("FAIL rand_pix i=%0d got %b %h want %b %h", i, sprite_on, {red, green, blue}, eon, ec); end
      n_vec++; if (anim_frame !== 2'(m_frame()) || anim_frame1 !== 2'(m_frame_once()) || anim_done1 !== (m_n >= NF * FH)) begin
        n_err++; $display("FAIL rand_anim i=%0d got %0d %0d %b want %0d %0d %b", i, anim_frame, anim_frame1, anim_done1,
                          m_frame(), m_frame_once(), m_n >= NF * FH); end
    end
  endtask

  initial begin
    Reset = 1'b1; blank = 1'b0; frame_start = 1'b0; flip = 1'b0; anim_en = 1'b0; anim_restart = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0; PosX = 10'd0; PosY = 10'd0;
    h1 = '0; h2 = '0; h3 = '0; m_px = 0; m_py = 0; m_flip = 1'b0; m_n = 0;
    for (int i = 0; i < NF * FSZ; i++) mem[i] = 4'($urandom);
    for (int i = 0; i < 16; i++) begin
      pal_tab[i] = 12'($urandom);
      if (pal_tab[i] == 12'hF0F) pal_tab[i] = 12'h123;
    end
    pal_tab[5] = 12'hF0F;
    pal_tab[9] = 12'h3A7;
    test_reset();
    test_static();
    test_flip();
    test_colour();
    test_animation();
    test_edges();
    test_reset_midline();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
